// File: rtl/neuron_argmax_collector.sv
// rtl/neuron_argmax_collector.sv - per-frame argmax over neuron results with valid/ready class output
// Optional runner-up/margin outputs when TOP2_EN is defined.
module neuron_argmax_collector #(
  parameter int NUM_NEURONS = 28,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = 5
) (
  input  logic                     clk,
  input  logic                     GlobalReset,
  input  logic                     Frame_Start,
  input  logic                     Result_Valid,
  input  logic signed [DATA_W-1:0] Result_In,
  input  logic                     Frame_Done,
  input  logic                     Class_Ready,
  output logic                     Class_Valid,
  output logic [IDX_W-1:0]         Class_Out,
  output logic signed [DATA_W-1:0] Max_Value,
  output logic                     Count_Err,
  output logic                     Overrun
`ifdef TOP2_EN
  ,
  output logic [IDX_W-1:0]         Second_Class,
  output logic [DATA_W:0]          Margin
`endif
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_NEURONS);
  localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  logic [1:0]               state;
  logic [CNT_W-1:0]         cnt, nxt_cnt;
  logic signed [DATA_W-1:0] run_max, nxt_max;
  logic [IDX_W-1:0]         run_idx, nxt_idx;
  logic                     ovf, nxt_ovf;
  logic                     in_collect, take, extra, gt_max, new_max;

  assign in_collect = (state == S_COLLECT);
  assign take       = in_collect && Result_Valid && (cnt < CNT_FULL);
  assign extra      = in_collect && Result_Valid && (cnt == CNT_FULL);
  assign gt_max     = (Result_In > run_max);
  // First result always wins so a frame of all-minimum values still reports index 0.
  assign new_max    = take && ((cnt == '0) || gt_max);
  assign nxt_ovf    = ovf | extra;
  assign Class_Valid = (state == S_HOLD);

  always_comb begin
    nxt_cnt = cnt;
    nxt_max = run_max;
    nxt_idx = run_idx;
    if (take) nxt_cnt = cnt + CNT_W'(1);
    if (new_max) begin
      nxt_max = Result_In;
      nxt_idx = cnt[IDX_W-1:0];
    end
  end

`ifdef TOP2_EN
  logic signed [DATA_W-1:0] sec_max, nxt_sec;
  logic [IDX_W-1:0]         sec_idx, nxt_sec_idx;
  logic [DATA_W:0]          diff;

  // A displaced maximum becomes the runner-up; otherwise the new value competes for second place.
  always_comb begin
    nxt_sec     = sec_max;
    nxt_sec_idx = sec_idx;
    if (new_max && (cnt != '0)) begin
      nxt_sec     = run_max;
      nxt_sec_idx = run_idx;
    end else if (take && !new_max && ((cnt == CNT_W'(1)) || (Result_In > sec_max))) begin
      nxt_sec     = Result_In;
      nxt_sec_idx = cnt[IDX_W-1:0];
    end
  end

  assign diff = {nxt_max[DATA_W-1], nxt_max} - {nxt_sec[DATA_W-1], nxt_sec};

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      sec_max      <= '0;
      sec_idx      <= '0;
      Second_Class <= '0;
      Margin       <= '0;
    end else if (Frame_Start) begin
      sec_max <= MIN_VAL;
      sec_idx <= '0;
    end else if (in_collect) begin
      sec_max <= nxt_sec;
      sec_idx <= nxt_sec_idx;
      if (Frame_Done) begin
        Second_Class <= (nxt_cnt >= CNT_W'(2)) ? nxt_sec_idx : '0;
        Margin       <= (nxt_cnt >= CNT_W'(2)) ? diff : '0;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      run_max   <= '0;
      run_idx   <= '0;
      ovf       <= 1'b0;
      Class_Out <= '0;
      Max_Value <= '0;
      Count_Err <= 1'b0;
      Overrun   <= 1'b0;
    end else if (Frame_Start) begin
      // A new frame always wins, including over a same-cycle Frame_Done.
      if ((state == S_HOLD) && !Class_Ready) Overrun <= 1'b1;
      state     <= S_COLLECT;
      cnt       <= '0;
      run_max   <= MIN_VAL;
      run_idx   <= '0;
      ovf       <= 1'b0;
      Count_Err <= 1'b0;
    end else begin
      case (state)
        S_COLLECT: begin
          cnt     <= nxt_cnt;
          run_max <= nxt_max;
          run_idx <= nxt_idx;
          ovf     <= nxt_ovf;
          if (Frame_Done) begin
            state     <= S_HOLD;
            Class_Out <= nxt_idx;
            Max_Value <= nxt_max;
            Count_Err <= (nxt_cnt != CNT_FULL) || nxt_ovf;
          end
        end
        S_HOLD: begin
          if (Class_Ready) state <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_argmax_collector.sv
// tb/tb_neuron_argmax_collector.sv - scoreboard bench for neuron_argmax_collector
module tb_neuron_argmax_collector;

  logic               clk = 1'b0;
  logic               GlobalReset = 1'b0;
  logic               Frame_Start = 1'b0;
  logic               Result_Valid = 1'b0;
  logic signed [15:0] Result_In = '0;
  logic               Frame_Done = 1'b0;
  logic               Class_Ready = 1'b1;
  logic               Class_Valid;
  logic [4:0]         Class_Out;
  logic signed [15:0] Max_Value;
  logic               Count_Err;
  logic               Overrun;
`ifdef TOP2_EN
  logic [4:0]         Second_Class;
  logic [16:0]        Margin;
`endif

  neuron_argmax_collector #(.NUM_NEURONS(28), .DATA_W(16), .IDX_W(5)) dut (
    .clk          (clk),
    .GlobalReset  (GlobalReset),
    .Frame_Start  (Frame_Start),
    .Result_Valid (Result_Valid),
    .Result_In    (Result_In),
    .Frame_Done   (Frame_Done),
    .Class_Ready  (Class_Ready),
    .Class_Valid  (Class_Valid),
    .Class_Out    (Class_Out),
    .Max_Value    (Max_Value),
    .Count_Err    (Count_Err),
    .Overrun      (Overrun)
`ifdef TOP2_EN
    ,
    .Second_Class (Second_Class),
    .Margin       (Margin)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int mx;
    int err;
    int sec;
    int mar;
  } exp_t;

  exp_t exp_q[$];
  int   vals[0:31];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endfunction

  function automatic void push(input int idx, input int mx, input int err, input int sec, input int mar);
    exp_t e;
    e.idx = idx; e.mx = mx; e.err = err; e.sec = sec; e.mar = mar;
    exp_q.push_back(e);
  endfunction

  // Monitor: every accepted transfer must match the oldest pending expectation.
  always @(negedge clk) begin
    if (GlobalReset && Class_Valid && Class_Ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_class", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("class_out", int'(Class_Out), e.idx);
        chk("max_value", int'(Max_Value), e.mx);
        chk("count_err", int'(Count_Err), e.err);
`ifdef TOP2_EN
        chk("second_class", int'(Second_Class), e.sec);
        chk("margin", int'(Margin), e.mar);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input bit done_last);
    Frame_Start = 1'b1;
    tick();
    Frame_Start = 1'b0;
    for (int k = 0; k < n; k++) begin
      Result_Valid = 1'b1;
      Result_In    = 16'(vals[k]);
      if (done_last && (k == n - 1)) Frame_Done = 1'b1;
      tick();
    end
    Result_Valid = 1'b0;
    if (!done_last || n == 0) begin
      Frame_Done = 1'b1;
      tick();
    end
    Frame_Done = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick();
    chk("drain_pending", exp_q.size(), 0);
    tick();
  endtask

  initial begin
    #2;
    chk("reset_valid", int'(Class_Valid), 0);
    chk("reset_overrun", int'(Overrun), 0);
    chk("reset_class", int'(Class_Out), 0);
    tick();
    GlobalReset = 1'b1;
    tick();

    // Ascending, last result shares the Frame_Done cycle.
    for (int k = 0; k < 28; k++) vals[k] = k;
    push(27, 27, 0, 26, 1);
    send(28, 1'b1);
    chk("latency_valid", int'(Class_Valid), 1);
    drain();

    for (int k = 0; k < 28; k++) vals[k] = -5;
    push(0, -5, 0, 1, 0);
    send(28, 1'b0);
    drain();

    for (int k = 0; k < 28; k++) vals[k] = (k == 13) ? -1 : -100;
    push(13, -1, 0, 0, 99);
    send(28, 1'b0);
    drain();

    for (int k = 0; k < 20; k++) vals[k] = 100 - k;
    push(0, 100, 1, 1, 1);
    send(20, 1'b0);
    drain();

    for (int k = 0; k < 30; k++) vals[k] = (k < 28) ? k : 1000;
    push(27, 27, 1, 26, 1);
    send(30, 1'b0);
    drain();

    push(0, -32768, 1, 0, 0);
    send(0, 1'b0);
    drain();

    // Start and Done together: the close is ignored and a fresh frame opens.
    for (int k = 0; k < 5; k++) vals[k] = 999;
    Frame_Start = 1'b1;
    tick();
    Frame_Start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      Result_Valid = 1'b1; Result_In = 16'(vals[k]); tick();
    end
    Result_Valid = 1'b0;
    Frame_Start = 1'b1; Frame_Done = 1'b1;
    tick();
    Frame_Start = 1'b0; Frame_Done = 1'b0;
    chk("collide_no_valid", int'(Class_Valid), 0);
    for (int k = 0; k < 28; k++) begin
      Result_Valid = 1'b1; Result_In = 16'(-k); tick();
    end
    Result_Valid = 1'b0;
    push(0, 0, 0, 1, 1);
    Frame_Done = 1'b1; tick(); Frame_Done = 1'b0;
    drain();

    // Back-pressure: outputs held for 10 cycles, then a new frame starts with Ready high.
    Class_Ready = 1'b0;
    for (int k = 0; k < 28; k++) vals[k] = (k == 5) ? 500 : -k;
    push(5, 500, 0, 0, 500);
    send(28, 1'b0);
    for (int c = 0; c < 10; c++) begin
      chk("hold_valid", int'(Class_Valid), 1);
      chk("hold_class", int'(Class_Out), 5);
      chk("hold_max", int'(Max_Value), 500);
      tick();
    end
    Class_Ready = 1'b1;
    for (int k = 0; k < 28; k++) vals[k] = k;
    push(27, 27, 0, 26, 1);
    send(28, 1'b1);
    chk("no_overrun_ready", int'(Overrun), 0);
    drain();

    // Frame_Start while a class is held and not accepted discards it.
    Class_Ready = 1'b0;
    for (int k = 0; k < 28; k++) vals[k] = (k == 13) ? -1 : -100;
    send(28, 1'b0);
    chk("held_before_overrun", int'(Class_Valid), 1);
    for (int k = 0; k < 28; k++) vals[k] = -5;
    push(0, -5, 0, 1, 0);
    send(28, 1'b0);
    chk("overrun_set", int'(Overrun), 1);
    chk("new_frame_held", int'(Class_Valid), 1);
    Class_Ready = 1'b1;
    drain();

    for (int k = 0; k < 28; k++) vals[k] = k;
    push(27, 27, 0, 26, 1);
    send(28, 1'b1);
    for (int k = 0; k < 28; k++) vals[k] = -5;
    push(0, -5, 0, 1, 0);
    send(28, 1'b0);
    chk("overrun_sticky", int'(Overrun), 1);
    drain();

    // Asynchronous reset with 12 results collected, away from any clock edge.
    for (int k = 0; k < 12; k++) vals[k] = 50 + k;
    Frame_Start = 1'b1;
    tick();
    Frame_Start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      Result_Valid = 1'b1; Result_In = 16'(vals[k]); tick();
    end
    Result_Valid = 1'b0;
    #2;
    GlobalReset = 1'b0;
    #1;
    chk("async_valid", int'(Class_Valid), 0);
    chk("async_class", int'(Class_Out), 0);
    chk("async_max", int'(Max_Value), 0);
    chk("async_err", int'(Count_Err), 0);
    chk("async_overrun", int'(Overrun), 0);
    #2;
    GlobalReset = 1'b1;
    tick();
    Frame_Done = 1'b1; tick(); Frame_Done = 1'b0;
    chk("post_reset_no_valid", int'(Class_Valid), 0);
    for (int k = 0; k < 28; k++) vals[k] = (k == 20) ? 300 : k;
    push(20, 300, 0, 27, 273);
    send(28, 1'b0);
    drain();

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
